// File: rtl/vec_mac_unit.sv
// -----------------------------------------------------------------------------
// vec_mac_unit
//
// Multi-lane signed multiply-accumulate engine. Each accepted input beat
// carries one signed weight and one signed activation per lane. The product
// is registered in stage 1 and added into a per-lane accumulator in stage 2.
// When the beat flagged as last has been absorbed, the per-lane sums, the
// beat count and the saturation flags are published as a held result.
//
// Optional feature (compile-time macro VEC_MAC_SAT_EN):
//   defined   -> each lane sum clamps to the signed ACC_WIDTH range and a
//                sticky per-lane flag records any clamp within the stream.
//   undefined -> lane sums wrap modulo 2^ACC_WIDTH and sat_flag is 0.
//
// Parameters:
//   DATA_WIDTH  signed operand width per lane
//   ACC_WIDTH   signed accumulator width per lane (>= 2*DATA_WIDTH)
//   LANES       number of independent MAC lanes
//   CNT_WIDTH   beat-counter width (saturates at all-ones)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input beat offered
//   in_ready   high in ACCUM only; beat accepted on in_valid && in_ready
//   in_last    accepted beat closes the stream
//   a_in       signed weights,     lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   b_in       signed activations, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  result held
//   out_ready  result consumed on out_valid && out_ready
//   acc_out    signed per-lane sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   beat_cnt   number of beats in the reported stream
//   sat_flag   per-lane saturation indicator for the reported stream
// -----------------------------------------------------------------------------
module vec_mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [LANES*DATA_WIDTH-1:0]   a_in,
  input  logic [LANES*DATA_WIDTH-1:0]   b_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*ACC_WIDTH-1:0]    acc_out,
  output logic [CNT_WIDTH-1:0]          beat_cnt,
  output logic [LANES-1:0]              sat_flag
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   accept;
  logic                   s1_valid_q;
  logic                   s1_last_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic [CNT_WIDTH-1:0]   beat_cnt_q;
  logic                   out_valid_q;

  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign beat_cnt  = beat_cnt_q;

  // Saturating beat count: holds at all-ones instead of wrapping.
  assign cnt_d = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Stage-1 control bits. The last bit marks the beat whose product is still
  // in flight while the FSM sits in FLUSH.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_last_q  <= accept && in_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered result handshake and beat counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (in_last) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          beat_cnt_q  <= cnt_q;
          cnt_q       <= '0;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane datapath.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] a_l;
    logic signed [DATA_WIDTH-1:0] b_l;
    logic signed [PROD_WIDTH-1:0] prod_d;
    logic signed [PROD_WIDTH-1:0] s1_prod_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_out_q;
    logic signed [ACC_WIDTH-1:0]  sum_d;

    assign a_l    = a_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_l    = b_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign prod_d = PROD_WIDTH'(a_l) * PROD_WIDTH'(b_l);

    // NOTE: the product register is pure datapath qualified by s1_valid_q,
    // so it carries no reset; only the valid/last bits need a known value.
    always_ff @(posedge clk) begin
      if (accept) s1_prod_q <= prod_d;
    end

`ifdef VEC_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] wide_sum;
    logic                      clamp_d;
    logic                      sticky_q;
    logic                      sat_out_q;

    // One guard bit exposes signed overflow: the top two bits disagree.
    assign wide_sum = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(s1_prod_q);
    assign clamp_d  = wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1];
    assign sum_d    = !clamp_d           ? wide_sum[ACC_WIDTH-1:0] :
                      wide_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;

    always_ff @(posedge clk) begin
      if (rst) begin
        sticky_q  <= 1'b0;
        sat_out_q <= 1'b0;
      end else if (state_q == FLUSH) begin
        sat_out_q <= sticky_q | (s1_last_q & clamp_d);
        sticky_q  <= 1'b0;
      end else if (s1_valid_q) begin
        sticky_q  <= sticky_q | clamp_d;
      end
    end

    assign sat_flag[i] = sat_out_q;
`else
    assign sum_d       = acc_q + ACC_WIDTH'(s1_prod_q);
    assign sat_flag[i] = 1'b0;
`endif

    // In FLUSH the final product is still in stage 1; fold it straight into
    // the published sum and start the next stream from zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q     <= '0;
        acc_out_q <= '0;
      end else if (state_q == FLUSH) begin
        acc_out_q <= s1_last_q ? sum_d : acc_q;
        acc_q     <= '0;
      end else if (s1_valid_q) begin
        acc_q     <= sum_d;
      end
    end

    assign acc_out[i*ACC_WIDTH +: ACC_WIDTH] = acc_out_q;
  end

endmodule

// File: doc/vec_mac_unit.md
VEC_MAC_UNIT -- requirements
Module: vec_mac_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed operand width per lane.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width per lane, ACC_WIDTH >= 2*DATA_WIDTH.
REQ-003 SHALL have parameter LANES, default 4: number of independent MAC lanes.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: beat-counter width.
REQ-005 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1: input beat offered.
REQ-008 SHALL have port in_ready  output  1: input beat accepted when in_valid && in_ready.
REQ-009 SHALL have port in_last  input  1: accepted beat is the final beat of a stream.
REQ-010 SHALL have port a_in  input  LANES*DATA_WIDTH: signed weights, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port b_in  input  LANES*DATA_WIDTH: signed activations, same packing.
REQ-012 SHALL have port out_valid  output  1: result held.
REQ-013 SHALL have port out_ready  input  1: result consumed when out_valid && out_ready.
REQ-014 SHALL have port acc_out  output  LANES*ACC_WIDTH: signed per-lane sums, lane i at [i*ACC_WIDTH +: ACC_WIDTH].
REQ-015 SHALL have port beat_cnt  output  CNT_WIDTH: beats in the reported stream, saturating at 2^CNT_WIDTH-1.
REQ-016 SHALL have port sat_flag  output  LANES: per-lane sticky saturation indicator for the reported stream.

Function
REQ-017 SHALL implement FSM states ACCUM, FLUSH, OUT; in_ready = (state==ACCUM), combinational from state only.
REQ-018 SHALL register each accepted beat's per-lane product (full 2*DATA_WIDTH signed) in stage 1, with a stage-1 valid bit and last bit.
REQ-019 SHALL, in stage 2, add the sign-extended stage-1 product to the lane accumulator whenever stage-1 valid is set.
REQ-020 SHALL transition ACCUM->FLUSH on an accepted beat with in_last=1.
REQ-021 SHALL, in FLUSH, load acc_out with accumulator+product, load beat_cnt and sat_flag, clear accumulators, counter and sticky flags to 0, and go to OUT.
REQ-022 SHALL assert out_valid in OUT only; latency from the last-beat handshake cycle N to out_valid is 2 cycles (out_valid high at cycle N+2).
REQ-023 SHALL hold acc_out, beat_cnt, sat_flag stable while out_valid && !out_ready.
REQ-024 SHALL go OUT->ACCUM on out_ready=1; in_ready rises the following cycle, never in the same cycle.
REQ-025 SHALL treat a single-beat stream (first beat has in_last=1) as a valid stream with beat_cnt=1.
REQ-026 SHALL ignore a_in, b_in, in_last when no handshake occurs; in_valid gaps in ACCUM do not alter accumulators.
REQ-027 SHALL hold beat_cnt at 2^CNT_WIDTH-1 once reached, without wrapping.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force state=ACCUM, stage-1 valid=0, accumulators=0, counter=0, flags=0, acc_out=0, beat_cnt=0, sat_flag=0, out_valid=0.
REQ-029 SHALL discard any partially accumulated stream or pending result on mid-operation reset; in_ready=1 the cycle after rst deasserts.

Configuration
REQ-030 SHALL, with macro VEC_MAC_SAT_EN defined, clamp each lane sum to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and set that lane's sticky flag on any clamp.
REQ-031 SHALL, without VEC_MAC_SAT_EN, wrap sums modulo 2^ACC_WIDTH and drive sat_flag constant 0.

Verification
REQ-032 SHALL cover: LANES=4, 3 beats a=all 2, b={1,2,3,4} per lane, last on beat 3 -> acc_out lanes {6,12,18,24}, beat_cnt=3, out_valid at N+2.
REQ-033 SHALL cover: single beat a=-128, b=-128, in_last=1 -> every lane 16384, beat_cnt=1.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> in_ready=0, outputs stable, in_ready=1 one cycle after out_ready pulse.
REQ-035 SHALL cover: ACC_WIDTH=16, 3 beats 127*127 with VEC_MAC_SAT_EN -> acc_out=32767, sat_flag=1; without -> acc_out=-17149 (48387 mod 2^16), sat_flag=0.
REQ-036 SHALL cover: rst asserted in FLUSH -> out_valid stays 0, next stream of 1 beat 3*5 -> result 15, beat_cnt=1.
REQ-037 SHALL cover: in_valid toggling 1,0,1,0,1(last) with a=1,b=1 -> acc_out=3 per lane, beat_cnt=3.
